// File: rtl/switch_allocator_if.sv
// switch_allocator_if: request/grant/select bundle between input buffers, crossbar and switch_allocator
interface switch_allocator_if;
  logic req_E, req_W, req_N, req_S, req_Inj;
  logic [2:0] dst_E, dst_W, dst_N, dst_S, dst_Inj;
  logic tail_E, tail_W, tail_N, tail_S, tail_Inj;
  logic credit_E, credit_W, credit_N, credit_S, credit_Ejec;
  logic gnt_E, gnt_W, gnt_N, gnt_S, gnt_Inj;
  logic [2:0] S_E, S_W, S_N, S_S, S_Ejec;
  modport master (
    output req_E, req_W, req_N, req_S, req_Inj,
    output dst_E, dst_W, dst_N, dst_S, dst_Inj,
    output tail_E, tail_W, tail_N, tail_S, tail_Inj,
    output credit_E, credit_W, credit_N, credit_S, credit_Ejec,
    input gnt_E, gnt_W, gnt_N, gnt_S, gnt_Inj,
    input S_E, S_W, S_N, S_S, S_Ejec
  );
  modport slave (
    input req_E, req_W, req_N, req_S, req_Inj,
    input dst_E, dst_W, dst_N, dst_S, dst_Inj,
    input tail_E, tail_W, tail_N, tail_S, tail_Inj,
    input credit_E, credit_W, credit_N, credit_S, credit_Ejec,
    output gnt_E, gnt_W, gnt_N, gnt_S, gnt_Inj,
    output S_E, S_W, S_N, S_S, S_Ejec
  );
endinterface

// File: rtl/switch_allocator.sv
// switch_allocator: 5x5 wormhole round-robin switch allocator; define SA_CREDIT_EN for per-output credit gating
module switch_allocator #(
  parameter int BUF_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  switch_allocator_if.slave bus
);
  typedef enum logic {FREE, LOCKED} lock_t;
  lock_t st [5];
  logic [4:0] req, tail, credit, gnt, win_v, elig, ok;
  logic [2:0] dst [5];
  logic [2:0] sel [5];
  logic [2:0] owner [5];
  logic [2:0] rr [5];
  logic [2:0] win [5];
  function automatic logic [2:0] inc5(input logic [2:0] a, input logic [2:0] k);
    logic [3:0] s;
    s = {1'b0, a} + {1'b0, k};
    return s >= 4'd5 ? 3'(s - 4'd5) : s[2:0];
  endfunction
  assign req = {bus.req_Inj, bus.req_S, bus.req_N, bus.req_W, bus.req_E};
  assign tail = {bus.tail_Inj, bus.tail_S, bus.tail_N, bus.tail_W, bus.tail_E};
  assign credit = {bus.credit_Ejec, bus.credit_S, bus.credit_N, bus.credit_W, bus.credit_E};
  assign dst = '{bus.dst_E, bus.dst_W, bus.dst_N, bus.dst_S, bus.dst_Inj};
  assign {bus.gnt_Inj, bus.gnt_S, bus.gnt_N, bus.gnt_W, bus.gnt_E} = gnt;
  assign bus.S_E = sel[0];
  assign bus.S_W = sel[1];
  assign bus.S_N = sel[2];
  assign bus.S_S = sel[3];
  assign bus.S_Ejec = sel[4];
  always_comb begin
    win_v = '0;
    elig = '0;
    gnt = '0;
    for (int o = 0; o < 5; o++) begin
      win[o] = owner[o];
      sel[o] = 3'd7;
      if (st[o] == LOCKED)
        win_v[o] = req[owner[o]] && dst[owner[o]] == 3'(o);
      else
        for (int k = 4; k >= 0; k--)
          if (req[inc5(rr[o], 3'(k))] && dst[inc5(rr[o], 3'(k))] == 3'(o)) begin
            win_v[o] = 1'b1;
            win[o] = inc5(rr[o], 3'(k));
          end
      elig[o] = win_v[o] && ok[o] && !rst;
      if (elig[o]) begin
        sel[o] = win[o];
        gnt[win[o]] = 1'b1;
      end
    end
  end
  always_ff @(posedge clk)
    if (rst) begin
      st <= '{default: FREE};
      owner <= '{default: 3'd0};
      rr <= '{default: 3'd0};
    end else
      for (int o = 0; o < 5; o++)
        if (elig[o]) begin
          if (tail[win[o]]) begin
            st[o] <= FREE;
            rr[o] <= inc5(win[o], 3'd1);
          end else if (st[o] == FREE) begin
            st[o] <= LOCKED;
            owner[o] <= win[o];
          end
        end
`ifdef SA_CREDIT_EN
  localparam int CW = $clog2(BUF_DEPTH + 1);
  logic [CW-1:0] cnt [5];
  always_ff @(posedge clk)
    if (rst) cnt <= '{default: CW'(BUF_DEPTH)};
    else
      for (int o = 0; o < 5; o++)
        if (elig[o] && !credit[o]) cnt[o] <= cnt[o] - CW'(1);
        else if (credit[o] && !elig[o] && cnt[o] != CW'(BUF_DEPTH)) cnt[o] <= cnt[o] + CW'(1);
  always_comb begin
    ok = '0;
    for (int o = 0; o < 5; o++) ok[o] = cnt[o] != '0;
  end
`else
  logic unused_credit;
  assign ok = '1;
  assign unused_credit = ^{credit, 32'(BUF_DEPTH)};
`endif
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: directed self-checking bench for switch_allocator
module tb_switch_allocator;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  switch_allocator_if bus();
  switch_allocator #(.BUF_DEPTH(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  logic [4:0] req = '0, tail = '0, credit = '0, gnt;
  logic [2:0] dst [5] = '{default: 3'd0};
  logic [14:0] sel;
  int n_chk = 0, n_fail = 0;
  localparam logic [2:0] X = 3'd7;
  assign {bus.req_Inj, bus.req_S, bus.req_N, bus.req_W, bus.req_E} = req;
  assign {bus.tail_Inj, bus.tail_S, bus.tail_N, bus.tail_W, bus.tail_E} = tail;
  assign {bus.credit_Ejec, bus.credit_S, bus.credit_N, bus.credit_W, bus.credit_E} = credit;
  assign bus.dst_E = dst[0];
  assign bus.dst_W = dst[1];
  assign bus.dst_N = dst[2];
  assign bus.dst_S = dst[3];
  assign bus.dst_Inj = dst[4];
  assign gnt = {bus.gnt_Inj, bus.gnt_S, bus.gnt_N, bus.gnt_W, bus.gnt_E};
  assign sel = {bus.S_Ejec, bus.S_S, bus.S_N, bus.S_W, bus.S_E};
  function automatic logic [14:0] sv(input logic [2:0] e, w, n, s, j);
    return {j, s, n, w, e};
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic look(input string tag, input logic [4:0] g, input logic [14:0] s);
    @(negedge clk);
    chk({tag, " gnt"}, 32'(gnt), 32'(g));
    chk({tag, " sel"}, 32'(sel), 32'(s));
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int i, input logic r, input logic [2:0] d, input logic t);
    req[i] = r;
    dst[i] = d;
    tail[i] = t;
  endtask
  task automatic do_reset;
    rst = 1'b1;
    req = '0;
    credit = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    put(0, 1, 2, 1);
    look("in_rst", 5'b00000, sv(X, X, X, X, X));
    rst = 1'b0;
    look("t1_e2n", 5'b00001, sv(X, X, 0, X, X));
    put(1, 1, 2, 1);
    look("t1_rr_w", 5'b00010, sv(X, X, 1, X, X));
    look("t1_rr_e", 5'b00001, sv(X, X, 0, X, X));
    do_reset;
    put(1, 1, 4, 1);
    put(3, 1, 4, 1);
    look("t2_w", 5'b00010, sv(X, X, X, X, 1));
    look("t2_s", 5'b01000, sv(X, X, X, X, 3));
    look("t2_w2", 5'b00010, sv(X, X, X, X, 1));
    req = '0;
    put(3, 1, 5, 1);
    look("bad_dst", 5'b00000, sv(X, X, X, X, X));
    do_reset;
    put(4, 1, 0, 0);
    look("t3_head", 5'b10000, sv(4, X, X, X, X));
    put(2, 1, 0, 1);
    look("t3_body", 5'b10000, sv(4, X, X, X, X));
    put(4, 1, 0, 1);
    look("t3_tail", 5'b10000, sv(4, X, X, X, X));
    req[4] = 1'b0;
    look("t3_next", 5'b00100, sv(2, X, X, X, X));
    do_reset;
    put(4, 1, 0, 0);
    look("t4_head", 5'b10000, sv(4, X, X, X, X));
    req[4] = 1'b0;
    put(2, 1, 0, 1);
    look("t4_bub1", 5'b00000, sv(X, X, X, X, X));
    look("t4_bub2", 5'b00000, sv(X, X, X, X, X));
    put(4, 1, 0, 1);
    look("t4_resume", 5'b10000, sv(4, X, X, X, X));
    req[4] = 1'b0;
    look("t4_n", 5'b00100, sv(2, X, X, X, X));
    do_reset;
    put(1, 1, 0, 0);
    look("t6_head", 5'b00010, sv(1, X, X, X, X));
    req[1] = 1'b0;
    put(2, 1, 0, 0);
    look("t6_locked", 5'b00000, sv(X, X, X, X, X));
    do_reset;
    put(2, 1, 0, 0);
    look("t6_after", 5'b00100, sv(2, X, X, X, X));
`ifdef SA_CREDIT_EN
    do_reset;
    credit[3] = 1'b1;
    look("t5_sat1", 5'b00000, sv(X, X, X, X, X));
    look("t5_sat2", 5'b00000, sv(X, X, X, X, X));
    credit = '0;
    put(1, 1, 3, 1);
    repeat (4) look("t5_grant", 5'b00010, sv(X, X, X, 1, X));
    look("t5_empty", 5'b00000, sv(X, X, X, X, X));
    credit[3] = 1'b1;
    look("t5_credit", 5'b00000, sv(X, X, X, X, X));
    look("t5_both", 5'b00010, sv(X, X, X, 1, X));
    credit = '0;
    look("t5_last", 5'b00010, sv(X, X, X, 1, X));
    look("t5_empty2", 5'b00000, sv(X, X, X, X, X));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
